// File: rtl/ifu_fetch_if.sv
// ----------------------------------------------------------------------------
// ifu_fetch_if : memory read bus and decode handshake of the fetch unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

interface ifu_fetch_if #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH
);
  logic                  ifu_rd_req;
  logic [ADDR_WIDTH-1:0] ifu_rd_addr;
  logic [DATA_WIDTH-1:0] ifu_rd_data;
  logic                  inst_valid;
  logic [DATA_WIDTH-1:0] inst_data;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic                  inst_ready;

  modport master (
    output ifu_rd_req, ifu_rd_addr, inst_valid, inst_data, inst_pc,
    input  ifu_rd_data, inst_ready
  );

  modport slave (
    input  ifu_rd_req, ifu_rd_addr, inst_valid, inst_data, inst_pc,
    output ifu_rd_data, inst_ready
  );
endinterface

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ----------------------------------------------------------------------------
// ifu_fetch : PC ownership, memory read issue and instruction buffer to decode
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module ifu_fetch #(
  parameter int                    ADDR_WIDTH = `ADDR_WIDTH,
  parameter int                    DATA_WIDTH = `DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 'o0200,
  parameter int                    BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  halt,
  input  logic                  redir_valid,
  input  logic [ADDR_WIDTH-1:0] redir_addr,
  ifu_fetch_if.master           bus
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(BUF_DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] tag_q, tag_d;
  logic                  inflight_q, inflight_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] buf_data_q [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0] buf_pc_q   [BUF_DEPTH];

  logic             head_valid;
  logic             pop;
  logic             push;
  logic             req;
  logic [CNT_W:0]   occupancy;

  always_comb begin
    head_valid = !rst && (count_q != '0);
    pop        = head_valid && bus.inst_ready;
    push       = inflight_q && !redir_valid;
    // Slots already owned by buffered or returning words, net of this cycle's pop.
    occupancy  = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    req        = !rst && !halt && !redir_valid && (occupancy < DEPTH_C);

    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = req;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (redir_valid) begin
      pc_d       = redir_addr;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      inflight_d = 1'b0;
    end else begin
      if (req) begin
        pc_d  = pc_q + ADDR_WIDTH'(1);
        tag_d = pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= START_ADDR;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if (push) begin
        buf_data_q[wr_ptr_q] <= bus.ifu_rd_data;
        buf_pc_q[wr_ptr_q]   <= tag_q;
      end
    end
  end

  // Empty or resetting buffer presents zeros so no stale word reaches decode.
  assign bus.ifu_rd_req  = req;
  assign bus.ifu_rd_addr = rst ? START_ADDR : pc_q;
  assign bus.inst_valid  = head_valid;
  assign bus.inst_data   = head_valid ? buf_data_q[rd_ptr_q] : '0;
  assign bus.inst_pc     = head_valid ? buf_pc_q[rd_ptr_q] : '0;

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ----------------------------------------------------------------------------
// tb_ifu_fetch : randomized fetch stimulus checked against a queue-based model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ifu_fetch;
  localparam int AW    = 12;
  localparam int DW    = 12;
  localparam int DEPTH = 2;
  localparam logic [AW-1:0] START = 'o0200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          halt = 1'b0;
  logic          redir_valid = 1'b0;
  logic [AW-1:0] redir_addr = '0;

  always #5 clk = ~clk;

  ifu_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ifu_fetch #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .START_ADDR(START),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .halt       (halt),
    .redir_valid(redir_valid),
    .redir_addr (redir_addr),
    .bus        (bus)
  );

  // Instruction memory: word appears in the cycle after its request, held otherwise.
  logic [DW-1:0] mem [0:4095];
  always @(posedge clk) begin
    if (bus.ifu_rd_req) bus.ifu_rd_data <= mem[bus.ifu_rd_addr];
  end

  // Behavioural model: current pc, one outstanding fetch, FIFO of delivered words.
  int m_pc;
  bit m_inflight;
  int m_tag;
  int q_data[$];
  int q_pc[$];
  bit e_req;
  bit e_pop;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic compare();
    logic [31:0] ev, ed, ep, ea;
    if (rst) begin
      e_req = 1'b0; e_pop = 1'b0;
      ea = 32'(START); ev = 0; ed = 0; ep = 0;
    end else begin
      ev    = (q_data.size() != 0) ? 1 : 0;
      ed    = (ev != 0) ? q_data[0] : 0;
      ep    = (ev != 0) ? q_pc[0] : 0;
      ea    = m_pc;
      e_pop = (ev != 0) && bus.inst_ready;
      e_req = !halt && !redir_valid &&
              ((q_data.size() + int'(m_inflight) - int'(e_pop)) < DEPTH);
    end
    chk("rd_req",     32'(bus.ifu_rd_req),  32'(e_req));
    chk("rd_addr",    32'(bus.ifu_rd_addr), ea);
    chk("inst_valid", 32'(bus.inst_valid),  ev);
    chk("inst_data",  32'(bus.inst_data),   ed);
    chk("inst_pc",    32'(bus.inst_pc),     ep);
  endtask

  task automatic drive(input bit r, input bit h, input bit rv, input int ra, input bit rdy);
    @(negedge clk);
    rst            = r;
    halt           = h;
    redir_valid    = rv;
    redir_addr     = ra[AW-1:0];
    bus.inst_ready = rdy;
    #1;
    compare();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_pc = START; m_inflight = 0; m_tag = 0;
      q_data.delete(); q_pc.delete();
    end else if (redir_valid) begin
      m_pc = redir_addr; m_inflight = 0;
      q_data.delete(); q_pc.delete();
    end else begin
      if (e_pop) begin
        void'(q_data.pop_front());
        void'(q_pc.pop_front());
      end
      if (m_inflight) begin
        q_data.push_back(int'(mem[m_tag]));
        q_pc.push_back(m_tag);
        chk("no_overflow", 32'(q_data.size() <= DEPTH), 32'd1);
      end
      if (e_req) begin
        m_tag = m_pc;
        m_pc  = (m_pc + 1) % 4096;
      end
      m_inflight = e_req;
    end
  endtask

  task automatic cycle(input bit r, input bit h, input bit rv, input int ra, input bit rdy);
    drive(r, h, rv, ra, rdy);
    tick();
  endtask

  initial begin
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom_range(0, 4095));

    // Reset state
    drive(1, 0, 0, 0, 1);
    chk("rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_addr",  32'(bus.ifu_rd_addr), 32'o0200);
    tick();
    cycle(1, 0, 0, 0, 1);

    // Streaming from reset with decode always ready
    drive(0, 0, 0, 0, 1);
    chk("t1_req0",  32'(bus.ifu_rd_req), 32'd1);
    chk("t1_addr0", 32'(bus.ifu_rd_addr), 32'o0200);
    tick();
    drive(0, 0, 0, 0, 1);
    chk("t1_addr1", 32'(bus.ifu_rd_addr), 32'o0201);
    chk("t1_nobyp", 32'(bus.inst_valid), 32'd0);
    tick();
    drive(0, 0, 0, 0, 1);
    chk("t1_valid", 32'(bus.inst_valid), 32'd1);
    chk("t1_pc",    32'(bus.inst_pc), 32'o0200);
    chk("t1_data",  32'(bus.inst_data), 32'(mem['o0200]));
    chk("t1_addr2", 32'(bus.ifu_rd_addr), 32'o0202);
    tick();
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1);

    // Redirect with a fetch in flight
    drive(0, 0, 1, 'o1000, 1);
    chk("t3_req_redir", 32'(bus.ifu_rd_req), 32'd0);
    tick();
    drive(0, 0, 0, 0, 1);
    chk("t3_addr", 32'(bus.ifu_rd_addr), 32'o1000);
    chk("t3_flushed", 32'(bus.inst_valid), 32'd0);
    tick();
    cycle(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    chk("t3_pc", 32'(bus.inst_pc), 32'o1000);
    tick();

    // Redirect near the top of memory, address wraps
    cycle(0, 0, 1, 'o7776, 1);
    drive(0, 0, 0, 0, 1);
    chk("t4_a0", 32'(bus.ifu_rd_addr), 32'o7776);
    tick();
    drive(0, 0, 0, 0, 1);
    chk("t4_a1", 32'(bus.ifu_rd_addr), 32'o7777);
    tick();
    drive(0, 0, 0, 0, 1);
    chk("t4_a2", 32'(bus.ifu_rd_addr), 32'o0000);
    chk("t4_pc", 32'(bus.inst_pc), 32'o7776);
    tick();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);

    // Backpressure from reset, then release
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("t2_stall", 32'(bus.ifu_rd_req), 32'd0);
    tick();
    cycle(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    chk("t2_pc0",  32'(bus.inst_pc), 32'o0200);
    chk("t2_req",  32'(bus.ifu_rd_req), 32'd1);
    chk("t2_addr", 32'(bus.ifu_rd_addr), 32'o0202);
    tick();
    drive(0, 0, 0, 0, 1);
    chk("t2_pc1", 32'(bus.inst_pc), 32'o0201);
    tick();

    // Halt with one buffered and one in flight
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 1);
      chk("t5_halted", 32'(bus.ifu_rd_req), 32'd0);
      tick();
    end
    drive(0, 0, 0, 0, 1);
    chk("t5_resume", 32'(bus.ifu_rd_addr), 32'o0202);
    chk("t5_req",    32'(bus.ifu_rd_req), 32'd1);
    tick();

    // Reset mid-operation
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("t6_rst_valid", 32'(bus.inst_valid), 32'd0);
    tick();
    drive(0, 0, 0, 0, 1);
    chk("t6_valid", 32'(bus.inst_valid), 32'd0);
    chk("t6_addr",  32'(bus.ifu_rd_addr), 32'o0200);
    tick();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int ra;
      ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4090, 4095))
                                       : int'($urandom_range(0, 4095));
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 5),
            ra,
            ($urandom_range(0, 99) < 70));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
